cic_rate_ctrl: RTL

- Run-time rate controller placed in front of a variable-rate CIC decimator (VARIABLE_RATE=1).
- Accepts rate-change requests over a ready/valid stream and validates them.
- Applies each valid rate to the decimator only at an output-sample boundary.
- Blanks the decimator's output while the comb chain settles, so downstream logic never sees samples that mix the old and new rates.

---
 rtl/cic_rate_ctrl_if.sv | 23 ++
 rtl/cic_rate_ctrl.sv | 65 ++++++
 2 files changed

// File: rtl/cic_rate_ctrl_if.sv
// cic_rate_ctrl_if: rate request, rate apply and sample streams around a variable-rate CIC decimator.
interface cic_rate_ctrl_if #(
    parameter int RATE_DW = 32,
    parameter int DATA_DW = 32
);
    logic [RATE_DW-1:0] s_axis_rate_tdata;
    logic               s_axis_rate_tvalid;
    logic               s_axis_rate_tready;
    logic [RATE_DW-1:0] m_axis_rate_tdata;
    logic               m_axis_rate_tvalid;
    logic [DATA_DW-1:0] cic_tdata;
    logic               cic_tvalid;
    logic [DATA_DW-1:0] m_axis_out_tdata;
    logic               m_axis_out_tvalid;
    modport master (
        output s_axis_rate_tdata, s_axis_rate_tvalid, cic_tdata, cic_tvalid,
        input  s_axis_rate_tready, m_axis_rate_tdata, m_axis_rate_tvalid, m_axis_out_tdata, m_axis_out_tvalid
    );
    modport slave (
        input  s_axis_rate_tdata, s_axis_rate_tvalid, cic_tdata, cic_tvalid,
        output s_axis_rate_tready, m_axis_rate_tdata, m_axis_rate_tvalid, m_axis_out_tdata, m_axis_out_tvalid
    );
endinterface

// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl: validates run-time rate requests, applies them at output-sample boundaries and blanks samples while the comb chain settles.
module cic_rate_ctrl #(
    parameter int RATE_DW        = 32,
    parameter int DATA_DW        = 32,
    parameter int CIC_R          = 10,
    parameter int SETTLE_SAMPLES = 7,
    parameter int TIMEOUT_CYC    = 1024,
    parameter int GATE_UNTIL_CFG = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    cic_rate_ctrl_if.slave     bus,
    output logic [RATE_DW-1:0] current_rate,
    output logic               busy,
    output logic               rate_err
);
    localparam logic [1:0] IDLE = 2'd0, WAIT_BND = 2'd1, APPLY = 2'd2, SETTLE = 2'd3;
    localparam int CMAX = TIMEOUT_CYC > SETTLE_SAMPLES ? TIMEOUT_CYC : SETTLE_SAMPLES;
    localparam int CW = $clog2(CMAX + 1);
    logic [1:0]    state, nxt;
    logic [CW-1:0] tcnt, scnt;
    logic          cfg_done, req, legal, suppress, settle_go;
    always_comb begin
        req       = bus.s_axis_rate_tvalid && bus.s_axis_rate_tready;
        legal     = bus.s_axis_rate_tdata != '0 && bus.s_axis_rate_tdata <= RATE_DW'(CIC_R);
        suppress  = state == APPLY || state == SETTLE || (GATE_UNTIL_CFG != 0 && !cfg_done);
        // a sample landing in the APPLY cycle already counts toward settling
        settle_go = SETTLE_SAMPLES > (bus.cic_tvalid ? 1 : 0);
        nxt = state == IDLE     ? (req && legal ? (cfg_done ? WAIT_BND : APPLY) : IDLE)
            : state == WAIT_BND ? (bus.cic_tvalid || tcnt == CW'(TIMEOUT_CYC - 1) ? APPLY : WAIT_BND)
            : state == APPLY    ? (settle_go ? SETTLE : IDLE)
            :                     (bus.cic_tvalid && scnt == CW'(1) ? IDLE : SETTLE);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                  <= IDLE;
            tcnt                   <= '0;
            scnt                   <= '0;
            cfg_done               <= 1'b0;
            current_rate           <= '0;
            rate_err               <= 1'b0;
            bus.s_axis_rate_tready <= 1'b0;
            bus.m_axis_rate_tvalid <= 1'b0;
            bus.m_axis_rate_tdata  <= '0;
            bus.m_axis_out_tvalid  <= 1'b0;
            bus.m_axis_out_tdata   <= '0;
        end else begin
            state                  <= nxt;
            bus.s_axis_rate_tready <= nxt == IDLE;
            bus.m_axis_rate_tvalid <= nxt == APPLY;
            rate_err               <= req && !legal;
            tcnt                   <= state == WAIT_BND ? tcnt + 1'b1 : '0;
            scnt <= state == APPLY ? (settle_go ? CW'(SETTLE_SAMPLES - (bus.cic_tvalid ? 1 : 0)) : '0)
                  : state == SETTLE && bus.cic_tvalid ? scnt - 1'b1 : scnt;
            if (req && legal) bus.m_axis_rate_tdata <= bus.s_axis_rate_tdata;
            if (state == APPLY) begin
                current_rate <= bus.m_axis_rate_tdata;
                cfg_done     <= 1'b1;
            end
            if (bus.cic_tvalid) bus.m_axis_out_tdata <= DATA_DW'(bus.cic_tdata);
            bus.m_axis_out_tvalid <= bus.cic_tvalid && !suppress;
        end
    end
    assign busy = state != IDLE;
endmodule
